// File: rtl/mod_arith_pkg.sv
// rtl/mod_arith_pkg.sv - shared FSM state type and quarter-slicing helpers for the modular adder
package mod_arith_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADD1 = 3'd1,
        ADD2 = 3'd2,
        ADD3 = 3'd3,
        SUB0 = 3'd4,
        SUB1 = 3'd5,
        SUB2 = 3'd6,
        SUB3 = 3'd7
    } state_t;

    // Which operand quarter a state works on; IDLE handles quarter 0 of the add.
    function automatic logic [1:0] quarter_of(input state_t st);
        case (st)
            ADD1, SUB1: quarter_of = 2'd1;
            ADD2, SUB2: quarter_of = 2'd2;
            ADD3, SUB3: quarter_of = 2'd3;
            default:    quarter_of = 2'd0;
        endcase
    endfunction

    function automatic logic is_sub_state(input state_t st);
        is_sub_state = (st == SUB0) || (st == SUB1) || (st == SUB2) || (st == SUB3);
    endfunction

endpackage

// File: rtl/mod_add_4_parts_if.sv
// rtl/mod_add_4_parts_if.sv - request/result bundle for the quarter-serial modular adder
interface mod_add_4_parts_if #(parameter int SIZE = 448);
    logic            start;
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic [SIZE-1:0] p;
    logic [SIZE-1:0] result;
    logic            done;

    modport master (output start, output a, output b, output p, input result, input done);
    modport slave  (input start, input a, input b, input p, output result, output done);
endinterface

// File: rtl/addsub_slice.sv
// rtl/addsub_slice.sv - W-bit combinational adder/subtractor slice with carry/borrow in and out
module addsub_slice #(
    parameter int W = 112
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cin,
    input  logic         sub,
    output logic [W-1:0] s,
    output logic         cout
);
    logic [W:0] sum;
    logic [W:0] y_ext;
    logic [W:0] c_ext;

    // Subtraction is x + ~y + ~borrow_in; carry-out of that sum is the inverse of borrow-out.
    always_comb begin
        y_ext = {1'b0, (sub ? ~y : y)};
        c_ext = {{W{1'b0}}, (sub ? ~cin : cin)};
        sum   = {1'b0, x} + y_ext + c_ext;
        s     = sum[W-1:0];
        cout  = sub ? ~sum[W] : sum[W];
    end
endmodule

// File: rtl/mod_add_4_parts.sv
// rtl/mod_add_4_parts.sv - (a + b) mod p computed one quarter-width slice per cycle
module mod_add_4_parts
    import mod_arith_pkg::*;
#(
    parameter int SIZE = 448
) (
    input  logic               clk,
    input  logic               rst_n,
    mod_add_4_parts_if.slave   bus
);
    localparam int Q = SIZE / 4;

    state_t          state;
    logic [SIZE-1:0] a_r;
    logic [SIZE-1:0] b_r;
    logic [SIZE-1:0] p_r;
    logic [SIZE-1:0] s_r;
    logic            carry_r;
    logic [3*Q-1:0]  d_r;
    logic            borrow_r;
    logic [SIZE-1:0] result_r;
    logic            done_r;

    logic [1:0]      q;
    logic            sub_phase;
    logic [SIZE-1:0] x_full;
    logic [SIZE-1:0] y_full;
    logic [Q-1:0]    sl_x;
    logic [Q-1:0]    sl_y;
    logic            sl_cin;
    logic [Q-1:0]    sl_s;
    logic            sl_cout;

    // Route the quarter for the current state into the shared slice; IDLE reads the live
    // inputs so quarter 0 is added on the same edge the operands are captured.
    always_comb begin
        q         = quarter_of(state);
        sub_phase = is_sub_state(state);
        x_full    = sub_phase ? s_r : ((state == IDLE) ? bus.a : a_r);
        y_full    = sub_phase ? p_r : ((state == IDLE) ? bus.b : b_r);
        sl_x      = x_full[q*Q +: Q];
        sl_y      = y_full[q*Q +: Q];
        if (state == IDLE || state == SUB0)
            sl_cin = 1'b0;
        else
            sl_cin = sub_phase ? borrow_r : carry_r;
    end

    addsub_slice #(.W(Q)) u_slice (
        .x    (sl_x),
        .y    (sl_y),
        .cin  (sl_cin),
        .sub  (sub_phase),
        .s    (sl_s),
        .cout (sl_cout)
    );

    // Sequencer: four add quarters build S, four subtract quarters build S - p, then select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_r      <= '0;
            b_r      <= '0;
            p_r      <= '0;
            s_r      <= '0;
            carry_r  <= 1'b0;
            d_r      <= '0;
            borrow_r <= 1'b0;
            result_r <= '0;
            done_r   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_r          <= bus.a;
                        b_r          <= bus.b;
                        p_r          <= bus.p;
                        s_r[Q-1:0]   <= sl_s;
                        carry_r      <= sl_cout;
                        done_r       <= 1'b0;
                        state        <= ADD1;
                    end
                end
                ADD1, ADD2, ADD3: begin
                    s_r[q*Q +: Q] <= sl_s;
                    carry_r       <= sl_cout;
                    state         <= (state == ADD1) ? ADD2 : (state == ADD2) ? ADD3 : SUB0;
                end
                SUB0: begin
                    d_r[Q-1:0] <= sl_s;
                    borrow_r   <= sl_cout;
                    state      <= SUB1;
                end
                SUB1: begin
                    d_r[2*Q-1:Q] <= sl_s;
                    borrow_r     <= sl_cout;
                    state        <= SUB2;
                end
                SUB2: begin
                    d_r[3*Q-1:2*Q] <= sl_s;
                    borrow_r       <= sl_cout;
                    state          <= SUB3;
                end
                SUB3: begin
                    // S >= p exactly when the sum overflowed SIZE bits or S - p did not borrow.
                    if (carry_r || !sl_cout)
                        result_r <= {sl_s, d_r};
                    else
                        result_r <= s_r;
                    borrow_r <= sl_cout;
                    done_r   <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.result = result_r;
    assign bus.done   = done_r;
endmodule

// File: tb/tb_mod_add_4_parts.sv
// tb/tb_mod_add_4_parts.sv - directed-vector bench for mod_add_4_parts at SIZE=16, p=0xFFF1
module tb_mod_add_4_parts;
    localparam int SIZE = 16;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    mod_add_4_parts_if #(.SIZE(SIZE)) bus ();

    mod_add_4_parts #(.SIZE(SIZE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One full operation with latency checks; prev is the result that must stay visible meanwhile.
    task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                          input logic [15:0] prev, input logic [15:0] exp, input bit chk_res);
        @(negedge clk);
        bus.a     = va;
        bus.b     = vb;
        bus.start = 1'b1;
        @(posedge clk); #1;
        check({tag, "_done_fall"}, {31'd0, bus.done}, 32'd0);
        bus.start = 1'b0;
        bus.a     = 16'hAAAA;
        bus.b     = 16'h5555;
        repeat (6) @(posedge clk);
        #1;
        check({tag, "_done_low_e6"}, {31'd0, bus.done}, 32'd0);
        check({tag, "_result_held"}, {16'd0, bus.result}, {16'd0, prev});
        @(posedge clk); #1;
        check({tag, "_done_rise_e7"}, {31'd0, bus.done}, 32'd1);
        if (chk_res)
            check({tag, "_result"}, {16'd0, bus.result}, {16'd0, exp});
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.p     = 16'hFFF1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_done", {31'd0, bus.done}, 32'd1);
        check("reset_result", {16'd0, bus.result}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("small",    16'h0001, 16'h0002, 16'h0000, 16'h0003, 1'b1);
        run_op("carry012", 16'h0FFF, 16'h0001, 16'h0003, 16'h1000, 1'b1);
        run_op("sum_cout", 16'hFFF0, 16'hFFF0, 16'h1000, 16'hFFEF, 1'b1);
        run_op("sum_eq_p", 16'h8000, 16'h7FF1, 16'hFFEF, 16'h0000, 1'b1);
        run_op("bad_pre",  16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 1'b0);

        // start held high: operands change mid-operation, second op begins the edge after done
        @(negedge clk);
        bus.a     = 16'h0005;
        bus.b     = 16'h0006;
        bus.start = 1'b1;
        @(posedge clk); #1;
        check("hold_done_fall", {31'd0, bus.done}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        bus.a = 16'h0100;
        bus.b = 16'h0200;
        repeat (4) @(posedge clk);
        #1;
        check("hold_done_rise", {31'd0, bus.done}, 32'd1);
        check("hold_result1", {16'd0, bus.result}, 32'h000B);
        @(posedge clk); #1;
        check("hold_restart", {31'd0, bus.done}, 32'd0);
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("hold_done2", {31'd0, bus.done}, 32'd1);
        check("hold_result2", {16'd0, bus.result}, 32'h0300);

        // asynchronous reset in SUB1 aborts the operation
        run_op("pre_rst", 16'h0FFF, 16'h0001, 16'h0300, 16'h1000, 1'b1);
        @(negedge clk);
        bus.a     = 16'h0001;
        bus.b     = 16'h0001;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_done", {31'd0, bus.done}, 32'd1);
        check("rst_async_result", {16'd0, bus.result}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_no_result_done", {31'd0, bus.done}, 32'd1);
        check("rst_no_result", {16'd0, bus.result}, 32'd0);
        run_op("post_rst", 16'h0002, 16'h0003, 16'h0000, 16'h0005, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mod_add_4_parts.md
MOD_ADD_4_PARTS -- requirements
Module: mod_add_4_parts

Interface
REQ-001 SHALL have parameter SIZE, default 448, giving the operand and modulus bit width; it must be divisible by 4.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-005 SHALL have port a, input, SIZE bits: addend, precondition a < p.
REQ-006 SHALL have port b, input, SIZE bits: addend, precondition b < p.
REQ-007 SHALL have port p, input, SIZE bits: modulus, precondition p > 0.
REQ-008 SHALL have port result, output, SIZE bits: (a + b) mod p, registered.
REQ-009 SHALL have port done, output, 1 bit: high when idle and result valid, low while busy.

Function
REQ-010 SHALL capture a, b and p into internal registers on the edge where start is sampled high in IDLE; inputs may change afterwards.
REQ-011 SHALL use FSM states IDLE, ADD1, ADD2, ADD3, SUB0, SUB1, SUB2, SUB3.
REQ-012 SHALL, in IDLE with start=1, compute quarter 0 of a+b (carry-in 0), store sum bits and carry, clear done, and go to ADD1.
REQ-013 SHALL, in ADD1/ADD2/ADD3, add quarter 1/2/3 of the captured operands plus the stored carry, store the sum quarter and carry-out, and advance one state per cycle.
REQ-014 SHALL, on leaving ADD3, hold the full SIZE+1-bit sum S, including the final carry.
REQ-015 SHALL, in SUB0..SUB3, compute quarter k of S[SIZE-1:0] - p with borrow propagated quarter to quarter (borrow-in 0 at SUB0), advancing one state per cycle.
REQ-016 SHALL, in SUB3, load result with D = S - p when S's carry bit is 1 or the final borrow is 0, otherwise with S[SIZE-1:0]; it then sets done=1 and returns to IDLE.
REQ-017 SHALL have a latency of 8 edges: done falls on the start edge and rises on the 7th edge after it.
REQ-018 SHALL ignore start while done=0; no restart and no operand recapture.
REQ-019 SHALL hold result stable from the done rising edge until the next SUB3 update; result is not disturbed during computation.
REQ-020 SHALL, in IDLE with start=0, hold all registers.
REQ-021 SHALL use only quarter-width (SIZE/4 + 1 bit) adders and subtractors per cycle, with no full-width carry chain.
REQ-022 SHALL leave results undefined for precondition violations (a >= p or b >= p) but still complete in 8 cycles with done=1.

Reset
REQ-023 SHALL, on rst_n low at any time (including mid-operation), immediately force state=IDLE, done=1, result=0, and clear all partial, carry and borrow registers and captured operands.
REQ-024 SHALL, after rst_n deasserts, accept a start on the first rising edge on which start is high; an operation aborted by reset produces no result.

Structure
REQ-025 SHALL declare the state enum type (3-bit encoding) in shared package mod_arith_pkg, alongside the arithmetic package contents.
REQ-026 SHALL instantiate one combinational sub-module, addsub_slice (parameter W=SIZE/4; inputs x, y, cin, sub; outputs s, cout), used for both the add and the subtract phases.
REQ-027 SHALL keep the FSM, operand capture, partial-quarter registers and final selection in mod_add_4_parts.

Verification (SIZE=16, p=0xFFF1)
REQ-028 SHALL cover: a=0x0001, b=0x0002, start pulse -> done low for 7 cycles, then result=0x0003, done=1.
REQ-029 SHALL cover: a=0x0FFF, b=0x0001 -> result=0x1000, exercising carry across quarters 0-2.
REQ-030 SHALL cover: a=0xFFF0, b=0xFFF0 (sum carry-out set) -> result=0xFFEF.
REQ-031 SHALL cover: a=0x8000, b=0x7FF1 (sum equals p) -> result=0x0000, exercising the borrow chain.
REQ-032 SHALL cover: start held high continuously with inputs changed at cycle 3 -> a single operation on the captured values; the next operation starts only on the cycle after done rises.
REQ-033 SHALL cover: rst_n pulsed low in SUB1 after a prior result 0x1000 -> done=1 and result=0x0000 asynchronously; a fresh a=2, b=3 then yields 0x0005.
